// File: rtl/frame_swap_ctrl.sv
// Double-buffered block frame controller.
// A producer streams BUFFER_SIZE blocks per frame into the back buffer. Once
// the back buffer is complete, the next frame start swaps it to the front. A
// frame start that arrives without a complete back buffer repeats the current
// front buffer and is counted as a drop. The display side reads the front
// buffer at the block under the raster position given by hc/vc.
module frame_swap_ctrl #(
    parameter int HPIXELS     = 640,
    parameter int VPIXELS     = 480,
    parameter int BLOCK_SIZE  = 16,
    parameter int BUFFER_SIZE = (HPIXELS / BLOCK_SIZE) * (VPIXELS / BLOCK_SIZE),
    localparam int AW         = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    hc,
    input  logic [9:0]    vc,
    input  logic          pix_valid,
    input  logic          pix_sof,
    input  logic [7:0]    pix_data,
    output logic          pix_ready,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          wr_en,
    output logic [AW-1:0] rd_addr,
    output logic          buf_sel,
    output logic          swap_pulse,
    output logic [15:0]   drop_count
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(BUFFER_SIZE - 1);
    localparam logic [31:0]   HPIX_U    = 32'(HPIXELS);
    localparam logic [31:0]   VPIX_U    = 32'(VPIXELS);
    localparam logic [31:0]   BLK_U     = 32'(BLOCK_SIZE);
    localparam logic [31:0]   HBLK_U    = 32'(HPIXELS / BLOCK_SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_next;
    logic [AW-1:0] wa_next;
    logic          we_next;
    logic          accept;
    logic          frame_start;
    logic          do_swap;
    logic [31:0]   hc_w;
    logic [31:0]   vc_w;
    logic          in_view;

    assign accept      = pix_valid && pix_ready;
    assign frame_start = (hc == 10'd0) && (vc == 10'd0);
    assign do_swap     = frame_start && (state == FULL);
    assign hc_w        = 32'(hc);
    assign vc_w        = 32'(vc);
    assign in_view     = (hc_w < HPIX_U) && (vc_w < VPIX_U);

    // State register, fill address and registered ready flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            pix_ready <= 1'b0;
        end else begin
            state     <= state_next;
            addr_q    <= addr_next;
            pix_ready <= (state_next != FULL);
        end
    end

    // Next-state logic: accept blocks into the back buffer, release on swap
    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        we_next    = 1'b0;
        wa_next    = addr_q;
        case (state)
            IDLE, FILL: begin
                // In IDLE only a start-of-frame block opens a new fill; in
                // FILL a start-of-frame block restarts the frame at 0.
                if (accept && (pix_sof || (state == FILL))) begin
                    we_next = 1'b1;
                    wa_next = pix_sof ? '0 : addr_q;
                    if (wa_next == LAST_ADDR) begin
                        state_next = FULL;
                        addr_next  = '0;
                    end else begin
                        state_next = FILL;
                        addr_next  = wa_next + AW'(1);
                    end
                end
            end
            FULL: begin
                if (frame_start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                addr_next  = '0;
            end
        endcase
    end

    // Back-buffer write port, one cycle after the accepting edge
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= we_next;
            if (we_next) begin
                wr_addr <= wa_next;
                wr_data <= pix_data;
            end
        end
    end

    // Buffer swap at frame start when full, otherwise count a repeated frame
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_sel    <= 1'b0;
            swap_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            swap_pulse <= do_swap;
            if (do_swap) begin
                buf_sel <= ~buf_sel;
            end else if (frame_start && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Front-buffer block address under the current raster position
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
        end else if (in_view) begin
            rd_addr <= AW'((vc_w / BLK_U) * HBLK_U + (hc_w / BLK_U));
        end else begin
            rd_addr <= '0;
        end
    end

endmodule
